// File: rtl/cache_backing_mem.sv
// Backing data memory for the cache refill path.
// It serves three kinds of request: single-word reads, critical-word-first line bursts,
// and byte-strobed word writes. Each request completes after a fixed access latency.
// Only one transaction is outstanding at a time. The array is not cleared by reset.
module cache_backing_mem #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4,
    parameter int LINE_WORDS  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic        mem_burst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    output logic        mem_rlast,
    output logic        mem_wack
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int BW = $clog2(LINE_WORDS) + 1;

    localparam logic [CW-1:0] CNT_LOAD  = CW'(LATENCY - 1);
    localparam logic [AW-1:0] OFF_MASK  = AW'(LINE_WORDS - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        BEAT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            rvalid_q, rvalid_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rlast_q, rlast_d;
    logic            wack_q, wack_d;

    // Request payload captured at acceptance.
    logic            we_q;
    logic            burst_q;
    logic [AW-1:0]   widx_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wstrb_q;

    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            accept;
    logic            commit;
    logic [AW-1:0]   beat_idx;

    // Address bits outside the word index are deliberately ignored (aliasing).
    logic            unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};

    assign accept    = (state_q == IDLE) && mem_req;
    assign mem_ready = (state_q == IDLE);
    assign mem_rvalid = rvalid_q;
    assign mem_rdata  = rdata_q;
    assign mem_rlast  = rlast_q;
    assign mem_wack   = wack_q;

    // Beat word: stay within the aligned line and wrap from the requested word.
    assign beat_idx = (widx_q & ~OFF_MASK) | ((widx_q + AW'(beat_q)) & OFF_MASK);

    // Next-state and output logic for the IDLE -> WAIT -> (BEAT) sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rlast_d  = rlast_q;
        wack_d   = 1'b0;
        commit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    cnt_d   = CNT_LOAD;
                    beat_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (we_q) begin
                        commit  = 1'b1;
                        wack_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rvalid_d = 1'b1;
                        rdata_d  = mem_q[beat_idx];
                        rlast_d  = !burst_q || (LINE_WORDS == 1);
                        beat_d   = beat_q + 1'b1;
                        state_d  = BEAT;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            BEAT: begin
                if (rlast_q) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    state_d  = IDLE;
                end else begin
                    rvalid_d = 1'b1;
                    rdata_d  = mem_q[beat_idx];
                    rlast_d  = (beat_q == LAST_BEAT);
                    beat_d   = beat_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and registered outputs; reset drops any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            beat_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rlast_q  <= 1'b0;
            wack_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rlast_q  <= rlast_d;
            wack_q   <= wack_d;
        end
    end

    // Payload capture; only meaningful while a transaction is in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= mem_we;
            burst_q <= mem_burst & ~mem_we;
            widx_q  <= mem_addr[AW+1:2];
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
        end
    end

    // Array write on the commit edge, enabled byte lanes only.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int k = 0; k < 4; k++) begin
                if (wstrb_q[k]) begin
                    mem_q[widx_q][8*k +: 8] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_backing_mem.sv
// Testbench for cache_backing_mem.
// Random and directed transactions are compared against a word-array reference model.
module tb_cache_backing_mem;

    localparam int DEPTH = 1024;
    localparam int LAT   = 4;
    localparam int LINE  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic        mem_burst = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_rlast;
    logic        mem_wack;

    always #5 clk = ~clk;

    cache_backing_mem #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT),
        .LINE_WORDS (LINE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_burst (mem_burst),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .mem_rlast (mem_rlast),
        .mem_wack  (mem_wack)
    );

    logic [31:0] ref_mem [DEPTH];
    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // mode 0: quiet, 1: random requests, 2: request held high (all must be ignored)
    task automatic drive_noise(input int mode);
        if (mode == 2)      mem_req = 1'b1;
        else if (mode == 1) mem_req = 1'($urandom_range(0, 1));
        else                mem_req = 1'b0;
        mem_we    = 1'($urandom_range(0, 1));
        mem_burst = 1'($urandom_range(0, 1));
        mem_addr  = $urandom();
        mem_wdata = $urandom();
        mem_wstrb = 4'($urandom());
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"},  mem_ready,  1);
        check_val({tag, "_rvalid"}, mem_rvalid, 0);
        check_val({tag, "_rdata"},  mem_rdata,  0);
        check_val({tag, "_rlast"},  mem_rlast,  0);
        check_val({tag, "_wack"},   mem_wack,   0);
        check_val({tag, "_nox"},
                  32'($isunknown({mem_ready, mem_rvalid, mem_rdata, mem_rlast, mem_wack})), 0);
    endtask

    // Called at posedge+1 with the responder idle; returns at posedge+1 with it idle again.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int noise);
        int w;
        w = word_of(addr);
        check_val("wr_ready_before", mem_ready, 1);
        mem_req = 1'b1; mem_we = 1'b1; mem_burst = 1'($urandom_range(0, 1));
        mem_addr = addr; mem_wdata = data; mem_wstrb = strb;
        @(posedge clk); #1;
        for (int k = 0; k <= LAT; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (k < LAT) begin
                check_val("wr_busy_ready", mem_ready, 0);
                check_val("wr_wack_early", mem_wack, 0);
                check_val("wr_rvalid", mem_rvalid, 0);
                drive_noise(noise);
            end else begin
                check_val("wr_wack", mem_wack, 1);
                check_val("wr_ready_at_ack", mem_ready, 1);
                check_val("wr_rvalid_at_ack", mem_rvalid, 0);
                mem_req = 1'b0;
            end
        end
        for (int b = 0; b < 4; b++)
            if (strb[b]) ref_mem[w][8*b +: 8] = data[8*b +: 8];
    endtask

    task automatic do_read(input logic [31:0] addr, input logic burst, input int noise,
                           output logic [31:0] first);
        int w;
        int n;
        logic [31:0] exp_q[$];
        w = word_of(addr);
        n = burst ? LINE : 1;
        first = '0;
        for (int i = 0; i < n; i++)
            exp_q.push_back(ref_mem[(w / LINE) * LINE + ((w % LINE) + i) % LINE]);
        check_val("rd_ready_before", mem_ready, 1);
        mem_req = 1'b1; mem_we = 1'b0; mem_burst = burst;
        mem_addr = addr; mem_wdata = $urandom(); mem_wstrb = 4'($urandom());
        @(posedge clk); #1;
        for (int k = 0; k <= LAT + n; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (k < LAT) begin
                check_val("rd_busy_ready", mem_ready, 0);
                check_val("rd_rvalid_early", mem_rvalid, 0);
                check_val("rd_rlast_early", mem_rlast, 0);
                check_val("rd_wack", mem_wack, 0);
                drive_noise(noise);
            end else if (k < LAT + n) begin
                if (k == LAT) first = mem_rdata;
                check_val("rd_rvalid", mem_rvalid, 1);
                check_val("rd_rdata", mem_rdata, exp_q[k - LAT]);
                check_val("rd_rlast", mem_rlast, (k == LAT + n - 1) ? 1 : 0);
                check_val("rd_beat_ready", mem_ready, 0);
                drive_noise(noise);
            end else begin
                check_val("rd_end_rvalid", mem_rvalid, 0);
                check_val("rd_end_rlast", mem_rlast, 0);
                check_val("rd_end_ready", mem_ready, 1);
                check_val("rd_hold_rdata", mem_rdata, exp_q[n - 1]);
                mem_req = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst_held");
        reset = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("rst_released");

        // Give every word in the low 64-word window a known value.
        for (int w = 0; w < 64; w++)
            do_write(32'(w * 4), $urandom(), 4'hF, 1);

        // Write then single read.
        do_write(32'h010, 32'h11111111, 4'hF, 0);
        do_read(32'h010, 1'b0, 0, got);
        check_val("t2_read", got, 32'h11111111);

        // Byte-lane merge, and an all-zero strobe leaves the word alone.
        do_write(32'h020, 32'hAABBCCDD, 4'hF, 0);
        do_write(32'h020, 32'hFFFFFF12, 4'b0001, 1);
        do_read(32'h020, 1'b0, 1, got);
        check_val("t3_merge", got, 32'hAABBCC12);
        do_write(32'h020, 32'h00000000, 4'b0000, 1);
        do_read(32'h020, 1'b0, 0, got);
        check_val("t3_nostrb", got, 32'hAABBCC12);

        // Critical-word-first burst with a request held high throughout.
        do_write(32'h040, 32'hA0, 4'hF, 0);
        do_write(32'h044, 32'hA1, 4'hF, 0);
        do_write(32'h048, 32'hA2, 4'hF, 0);
        do_write(32'h04C, 32'hA3, 4'hF, 0);
        do_read(32'h048, 1'b1, 2, got);
        check_val("t4_first", got, 32'hA2);
        check_val("t4_last_held", mem_rdata, 32'hA1);

        // Upper address bits alias.
        do_write(32'h1010, 32'h5555AAAA, 4'hF, 0);
        do_read(32'h0010, 1'b0, 0, got);
        check_val("t5_alias", got, 32'h5555AAAA);

        // Reset two cycles into a write drops it.
        do_write(32'h030, 32'h11111111, 4'hF, 0);
        mem_req = 1'b1; mem_we = 1'b1; mem_burst = 1'b0;
        mem_addr = 32'h030; mem_wdata = 32'hDEADBEEF; mem_wstrb = 4'hF;
        @(posedge clk); #1;
        mem_req = 1'b0;
        check_val("t6_busy", mem_ready, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("t6_rst");
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_val("t6_no_wack_rst", mem_wack, 0);
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_val("t6_no_wack", mem_wack, 0);
            check_val("t6_idle", mem_ready, 1);
        end
        do_read(32'h030, 1'b0, 0, got);
        check_val("t6_unchanged", got, 32'h11111111);

        // Randomized mix inside the initialized window, with aliasing upper bits.
        for (int t = 0; t < 300; t++) begin
            a = $urandom();
            a[11:8] = 4'h0;
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom(), 4'($urandom()), 1);
            else
                do_read(a, 1'($urandom_range(0, 1)), 1, got);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "time limit reached");
    end

endmodule

// File: doc/cache_backing_mem.md
Name: cache_backing_mem

Overview:
- Backing data-memory responder on the miss/refill side of the data cache.
- Serves single-word reads, critical-word-first line-fill bursts and byte-strobed word writes, each after a fixed access latency.
- One outstanding transaction at a time; request/ready handshake on the request side, valid/last on the read-return side.
- Synthesizable; also the memory model for cache benches.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two).
LATENCY, 4, cycles from request acceptance to first read beat or write commit; must be >= 1.
LINE_WORDS, 4, words per cache line in a burst (power of two; 4 matches 16-byte lines).

Ports:
clk  in  1  clock, all state on rising edge.
reset  in  1  asynchronous, active-high reset.
mem_req  in  1  request valid.
mem_we  in  1  1 = write, 0 = read.
mem_burst  in  1  read of a full line; ignored when mem_we=1.
mem_addr  in  32  byte address; bits [1:0] ignored.
mem_wdata  in  32  write data.
mem_wstrb  in  4  byte enables; bit k enables byte lane k.
mem_ready  out  1  responder idle and accepting.
mem_rvalid  out  1  read beat valid.
mem_rdata  out  32  read beat data.
mem_rlast  out  1  final beat of a read.
mem_wack  out  1  one-cycle write-commit pulse.

Behaviour:
- Reset values (async): mem_ready=1, mem_rvalid=0, mem_rdata=0, mem_rlast=0, mem_wack=0, state=IDLE, counters=0. Array contents are unaffected by reset.
- Word index = mem_addr[log2(DEPTH_WORDS)+1:2]. Upper bits are ignored, so addresses alias modulo the array size.
- Acceptance occurs at edge E0 where mem_req && mem_ready. At E0 the responder captures we, burst, addr, wdata and wstrb, loads the latency counter with LATENCY-1, moves to WAIT and drops mem_ready.
- A mem_req while mem_ready=0 is ignored; no queuing.
- States:
  - IDLE: mem_ready=1.
  - WAIT: counter decrements each edge. At the edge where the counter is 0 (edge E0+LATENCY):
    - write: the array word is updated on enabled byte lanes only; mem_wack=1 for exactly one cycle; next state IDLE, with mem_ready=1 in the same cycle as mem_wack.
    - read: the first beat is registered (mem_rvalid=1); next state BEAT.
  - BEAT: one beat per cycle, no stalls.
    - Single read: 1 beat with mem_rlast=1.
    - Burst: LINE_WORDS beats starting at the requested word and wrapping within the aligned line. Beat i returns line word (start+i) mod LINE_WORDS; e.g. start word 2 gives 2,3,0,1. mem_rlast=1 on the last beat only.
    - At the edge after the last beat: mem_rvalid=0, mem_rlast=0, mem_ready=1, state IDLE.
- mem_rdata holds its last value when mem_rvalid=0.
- Beat data is read from the array at beat time, so it reflects all committed writes.
- Total occupancy: write LATENCY cycles; single read LATENCY+1; burst LATENCY+LINE_WORDS.
- Back-to-back: a new request may be accepted on the first edge where mem_ready=1.
- Reset mid-operation: the transaction is dropped and outputs return to reset values. A write reset before its commit edge leaves the array unchanged.
- mem_wstrb=0000: the write still completes with mem_wack and leaves the array unchanged.

Test Plan (LATENCY=4, LINE_WORDS=4, DEPTH_WORDS=1024):
1. Assert reset for 3 cycles, then release -> mem_ready=1, mem_rvalid=0, mem_rdata=0, mem_rlast=0, mem_wack=0; no X on any output.
2. Write 0x11111111 to 0x010 with wstrb=1111 -> mem_wack high exactly 4 cycles after acceptance for 1 cycle. Then single read of 0x010 -> mem_rvalid 4 cycles after acceptance, mem_rdata=0x11111111, mem_rlast=1, mem_ready high the following cycle.
3. Write 0xAABBCCDD to 0x020 with wstrb=1111, then write 0xFFFFFF12 with wstrb=0001 -> read 0x020 returns 0xAABBCC12.
4. Load 0x040/0x044/0x048/0x04C with 0xA0,0xA1,0xA2,0xA3, then burst read 0x048 -> 4 consecutive beats 0xA2,0xA3,0xA0,0xA1; mem_rlast only on 0xA1; mem_ready=0 throughout and 1 the cycle after. A mem_req pulsed mid-burst is ignored.
5. Aliasing: write 0x5555AAAA to 0x1010 -> read 0x0010 returns 0x5555AAAA.
6. Write 0x11111111 to 0x030, then write 0xDEADBEEF to 0x030 and assert reset 2 cycles after acceptance -> no mem_wack; read 0x030 after reset returns 0x11111111.
